// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver with a one-entry holding register.
//
// Frame: start (0), 8 data bits MSB first, optional even parity bit
// (XOR of the data bits), stop (1). The line idles high.
//
// The serial input is brought into the rx_clk domain with a two-flop
// synchronizer. A 1->0 edge on the synchronized line starts a frame. The
// start bit is re-checked half a bit later; every following bit is sampled
// one full bit period after the previous sample, i.e. at its mid-point.
// Completed frames (including those with parity/framing errors) are
// offered on a valid/ready handshake from a single holding register.
//
// Parameters:
//   OVERSAMPLE  rx_clk cycles per serial bit; must be even and >= 4.
//   PARITY_EN   1: parity bit expected and checked; 0: no parity bit.
//
// Ports:
//   rx_clk           receiver clock
//   rx_rst           asynchronous active-high reset
//   rx_i             serial data in (asynchronous to rx_clk)
//   rx_i_ready       consumer ready to accept the held byte
//   rx_o_data        received byte
//   rx_o_data_valid  rx_o_data and error flags are valid
//   rx_o_parity_err  parity mismatch on the held byte (qualified by valid)
//   rx_o_frame_err   stop bit sampled 0 on the held byte (qualified by valid)
//   rx_o_overrun     one-cycle pulse: completed frame dropped, holder full
//   rx_o_busy        high whenever the receiver FSM is not idle
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          PARITY_EN  = 1'b1
) (
  input  logic       rx_clk,
  input  logic       rx_rst,
  input  logic       rx_i,
  input  logic       rx_i_ready,
  output logic [7:0] rx_o_data,
  output logic       rx_o_data_valid,
  output logic       rx_o_parity_err,
  output logic       rx_o_frame_err,
  output logic       rx_o_overrun,
  output logic       rx_o_busy
);

  localparam int unsigned CW   = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned HALF = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Synchronizer and edge-detect history. All reset to 1 so that reset
  // release on an idle line never looks like a falling edge.
  logic sync1_q;
  logic rx_s_q;
  logic prev_q;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [2:0]      bit_q,   bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            perr_q,  perr_d;   // parity result of the frame in flight

  // Holding register.
  logic [7:0]      data_q,  data_d;
  logic            valid_q, valid_d;
  logic            hperr_q, hperr_d;
  logic            hferr_q, hferr_d;
  logic            ovr_q,   ovr_d;

  logic            fall;
  logic            half_tick;
  logic            full_tick;
  logic            done;
  logic            load;

  assign fall      = prev_q & ~rx_s_q;
  assign half_tick = (cnt_q == CW'(HALF - 1));
  assign full_tick = (cnt_q == CW'(OVERSAMPLE - 1));

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      rx_s_q  <= sync1_q;
      prev_q  <= rx_s_q;
    end
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      hperr_q <= 1'b0;
      hferr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      hperr_q <= hperr_d;
      hferr_q <= hferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Receive FSM: next state and shift/count datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        perr_d = 1'b0;
        if (fall) begin
          state_d = START;
        end
      end
      START: begin
        if (half_tick) begin
          cnt_d = '0;
          // Line back high at the start mid-point: glitch, drop silently.
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (full_tick) begin
          cnt_d   = '0;
          shift_d = {shift_q[6:0], rx_s_q};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (full_tick) begin
          cnt_d   = '0;
          perr_d  = rx_s_q ^ (^shift_q);
          state_d = STOP;
        end
      end
      STOP: begin
        if (full_tick) begin
          cnt_d = '0;
          done  = 1'b1;
          // Return to IDLE at the stop mid-point so a following start edge
          // is caught even if the stop bit is short.
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register: a completed frame loads if the register is empty or
  // is being drained in the same cycle; otherwise it is dropped and the
  // overrun pulse fires.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    hperr_d = hperr_q;
    hferr_d = hferr_q;
    load    = done & (~valid_q | rx_i_ready);
    ovr_d   = done & ~load;

    if (load) begin
      data_d  = shift_q;
      hperr_d = perr_q;
      hferr_d = ~rx_s_q;
      valid_d = 1'b1;
    end else if (valid_q & rx_i_ready) begin
      valid_d = 1'b0;
    end
  end

  assign rx_o_data       = data_q;
  assign rx_o_data_valid = valid_q;
  assign rx_o_parity_err = hperr_q;
  assign rx_o_frame_err  = hferr_q;
  assign rx_o_overrun    = ovr_q;
  assign rx_o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed bench for uart_rx (OVERSAMPLE = 16, parity on).
// Expected bytes/flags are queued when a frame is driven and popped by a
// monitor whenever the DUT hands a byte over (valid & ready).
module tb_uart_rx;

  localparam int OS = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_perr;
  logic       o_ferr;
  logic       o_ovr;
  logic       o_busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int valid_cycles = 0;
  int ov_cycles = 0;
  int busy_cycles = 0;
  int last_rise = 0;
  logic valid_prev = 1'b0;

  exp_t sb[$];

  always #5 clk = ~clk;

  uart_rx #(
    .OVERSAMPLE(OS),
    .PARITY_EN (1'b1)
  ) dut (
    .rx_clk         (clk),
    .rx_rst         (rst),
    .rx_i           (rx_i),
    .rx_i_ready     (ready),
    .rx_o_data      (o_data),
    .rx_o_data_valid(o_valid),
    .rx_o_parity_err(o_perr),
    .rx_o_frame_err (o_ferr),
    .rx_o_overrun   (o_ovr),
    .rx_o_busy      (o_busy)
  );

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) valid_cycles++;
      if (o_valid && !valid_prev) last_rise = cyc;
      if (o_ovr) ov_cycles++;
      if (o_busy) busy_cycles++;
      if (o_valid && ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("[%0t] rx byte 0x%02h perr=%0b ferr=%0b (expected 0x%02h perr=%0b ferr=%0b)",
                   $time, o_data, o_perr, o_ferr, e.d, e.pe, e.fe);
          check("rx_data", 32'(o_data), 32'(e.d));
          check("rx_perr", 32'(o_perr), 32'(e.pe));
          check("rx_ferr", 32'(o_ferr), 32'(e.fe));
        end
      end
    end
    valid_prev = rst ? 1'b0 : o_valid;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first nbits of the 11-bit line frame, each held OS cycles.
  task automatic send_frame(input logic [7:0] d, input logic par_flip,
                            input logic stop_bit, input int nbits);
    logic [10:0] line;
    line = {1'b0, d, (^d) ^ par_flip, stop_bit};
    for (int i = 0; i < nbits; i++) begin
      rx_i = line[10-i];
      wait_cyc(OS);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, v0, o0, b0;
    logic [7:0] ab;

    // Reset state
    rst = 1'b1; rx_i = 1'b1; ready = 1'b0;
    wait_cyc(3);
    check("rst_data",  32'(o_data),  32'h0);
    check("rst_valid", 32'(o_valid), 32'h0);
    check("rst_perr",  32'(o_perr),  32'h0);
    check("rst_ferr",  32'(o_ferr),  32'h0);
    check("rst_ovr",   32'(o_ovr),   32'h0);
    check("rst_busy",  32'(o_busy),  32'h0);
    rst = 1'b0;
    wait_cyc(5);

    // 0xA5, clean; valid appears 2 sync cycles + 169 after the start drive
    ready = 1'b1;
    v0 = valid_cycles;
    sb.push_back({8'hA5, 1'b0, 1'b0});
    t0 = cyc;
    send_frame(8'hA5, 1'b0, 1'b1, 11);
    wait_cyc(20);
    check("a5_latency", 32'(last_rise - t0), 32'd171);
    check("a5_valid_len", 32'(valid_cycles - v0), 32'd1);

    // 0x01 with wrong parity bit
    sb.push_back({8'h01, 1'b1, 1'b0});
    send_frame(8'h01, 1'b1, 1'b1, 11);
    wait_cyc(20);

    // 0xFF with stop bit 0; line stays low and must not retrigger
    sb.push_back({8'hFF, 1'b0, 1'b1});
    send_frame(8'hFF, 1'b0, 1'b0, 11);
    b0 = busy_cycles;
    wait_cyc(40);
    check("no_retrigger_busy", 32'(busy_cycles - b0), 32'd0);
    rx_i = 1'b1;
    wait_cyc(20);
    sb.push_back({8'h42, 1'b0, 1'b0});
    send_frame(8'h42, 1'b0, 1'b1, 11);
    wait_cyc(20);

    // False start: 4 low cycles
    b0 = busy_cycles;
    v0 = valid_cycles;
    rx_i = 1'b0;
    wait_cyc(4);
    rx_i = 1'b1;
    wait_cyc(40);
    check("false_start_busy", 32'(busy_cycles - b0), 32'(OS / 2));
    check("false_start_valid", 32'(valid_cycles - v0), 32'd0);

    // Overrun: ready low, 0x3C then 0xC3 back-to-back
    ready = 1'b0;
    o0 = ov_cycles;
    sb.push_back({8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b0, 1'b1, 11);
    send_frame(8'hC3, 1'b0, 1'b1, 11);
    wait_cyc(20);
    check("ovr_pulse_len", 32'(ov_cycles - o0), 32'd1);
    check("ovr_valid_held", 32'(o_valid), 32'd1);
    check("ovr_data_held", 32'(o_data), 32'h3C);
    ready = 1'b1;
    wait_cyc(1);
    check("ovr_valid_drop", 32'(o_valid), 32'd0);
    ready = 1'b0;
    wait_cyc(5);

    // Ready raised exactly in the completion cycle of 0x5A
    sb.push_back({8'h3C, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b0, 1'b1, 11);
    wait_cyc(5);
    o0 = ov_cycles;
    sb.push_back({8'h5A, 1'b0, 1'b0});
    fork
      send_frame(8'h5A, 1'b0, 1'b1, 11);
      begin
        wait_cyc(170);
        ready = 1'b1;
        wait_cyc(1);
        ready = 1'b0;
        check("swap_valid", 32'(o_valid), 32'd1);
        check("swap_data", 32'(o_data), 32'h5A);
      end
    join
    check("swap_no_ovr", 32'(ov_cycles - o0), 32'd0);
    ready = 1'b1;
    wait_cyc(5);

    // Reset during data bit 4 of 0x96, then a clean 0x96
    ab = 8'h96;
    v0 = valid_cycles;
    o0 = ov_cycles;
    send_frame(ab, 1'b0, 1'b1, 5);
    rx_i = ab[3];
    wait_cyc(8);
    rst = 1'b1;
    rx_i = 1'b1;
    wait_cyc(3);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_valid", 32'(o_valid), 32'd0);
    rst = 1'b0;
    wait_cyc(200);
    check("abort_no_valid", 32'(valid_cycles - v0), 32'd0);
    check("abort_no_ovr", 32'(ov_cycles - o0), 32'd0);
    sb.push_back({8'h96, 1'b0, 1'b0});
    send_frame(8'h96, 1'b0, 1'b1, 11);
    wait_cyc(20);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
